// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, writable instruction memory and a
// prefetch FIFO of {PC, instruction} drained by decode over valid/ready.
module if_fetch_queue #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    IM_AW    = 10,
    parameter int unsigned    QDEPTH   = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              newPC,
    input  logic                         WE,
    input  logic [XLEN-1:0]              W_Addr,
    input  logic [XLEN-1:0]              W_Ins,
    output logic [XLEN-1:0]              PC,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_PC,
    output logic [XLEN-1:0]              out_nextPC,
    output logic [XLEN-1:0]              out_Ins,
    output logic [$clog2(QDEPTH):0]      count,
    output logic                         align_err
);

    localparam int unsigned PW       = $clog2(QDEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned IM_WORDS = 2 ** IM_AW;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            align_q, align_d;

    logic [XLEN-1:0] im_q    [IM_WORDS];
    logic [XLEN-1:0] qpc_q   [QDEPTH];
    logic [XLEN-1:0] qins_q  [QDEPTH];

    logic [IM_AW-1:0] fetch_idx;
    logic [IM_AW-1:0] write_idx;
    logic [XLEN-1:0]  fetch_ins;
    logic             pop;
    logic             push;
    logic             unused_waddr;

    assign fetch_idx    = pc_q[IM_AW+1:2];
    assign write_idx    = W_Addr[IM_AW+1:2];
    assign fetch_ins    = im_q[fetch_idx];
    assign unused_waddr = ^{W_Addr[XLEN-1:IM_AW+2], W_Addr[1:0]};

    // Handshake: pop when head is valid and taken; push unless redirecting or full without a pop
    assign pop  = (count_q != '0) & out_ready;
    assign push = ~redirect & ((count_q < CW'(QDEPTH)) | pop);

    // Instruction memory write port; a same-cycle fetch sees the old word
    always_ff @(posedge CLK) begin
        if (WE) begin
            im_q[write_idx] <= W_Ins;
        end
    end

    // FIFO payload storage, written at the tail on push
    always_ff @(posedge CLK) begin
        if (push) begin
            qpc_q[wr_ptr_q]  <= pc_q;
            qins_q[wr_ptr_q] <= fetch_ins;
        end
    end

    // Next-state for PC, pointers, occupancy and alignment flag
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        align_d  = 1'b0;
        if (redirect) begin
            // Flush: any concurrent pop is already consumed by decode
            pc_d     = {newPC[XLEN-1:2], 2'b00};
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            align_d  = |newPC[1:0];
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            align_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            align_q  <= align_d;
        end
    end

    assign PC         = pc_q;
    assign out_valid  = (count_q != '0);
    assign out_PC     = qpc_q[rd_ptr_q];
    assign out_Ins    = qins_q[rd_ptr_q];
    assign out_nextPC = qpc_q[rd_ptr_q] + XLEN'(4);
    assign count      = count_q;
    assign align_err  = align_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_if_fetch_queue;

    logic        CLK;
    // default-parameter instance
    logic        rst, redirect, we, ready;
    logic [31:0] new_pc, w_addr, w_ins;
    logic [31:0] pc, out_pc, out_next_pc, out_ins;
    logic        out_valid, align_err;
    logic [2:0]  count;
    // wrap-around instance
    logic        rst6, redirect6, we6, ready6;
    logic [31:0] new_pc6, w_addr6, w_ins6;
    logic [31:0] pc6, out_pc6, out_next_pc6, out_ins6;
    logic        out_valid6, align_err6;
    logic [2:0]  count6;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_queue u_dut (
        .CLK(CLK), .RST(rst), .redirect(redirect), .newPC(new_pc),
        .WE(we), .W_Addr(w_addr), .W_Ins(w_ins), .PC(pc),
        .out_valid(out_valid), .out_ready(ready), .out_PC(out_pc),
        .out_nextPC(out_next_pc), .out_Ins(out_ins), .count(count),
        .align_err(align_err)
    );

    if_fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .IM_AW(2), .QDEPTH(4)) u_dut6 (
        .CLK(CLK), .RST(rst6), .redirect(redirect6), .newPC(new_pc6),
        .WE(we6), .W_Addr(w_addr6), .W_Ins(w_ins6), .PC(pc6),
        .out_valid(out_valid6), .out_ready(ready6), .out_PC(out_pc6),
        .out_nextPC(out_next_pc6), .out_Ins(out_ins6), .count(count6),
        .align_err(align_err6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model of the default instance
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_align;
    logic [31:0] m_im [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t        e;
        logic [31:0] fetched;
        bit          do_pop, do_push;
        fetched = m_im[m_pc[11:2]];
        if (rst) begin
            m_pc    = 32'h0;
            m_align = 1'b0;
            m_q.delete();
        end else if (redirect) begin
            m_q.delete();
            m_pc    = new_pc & 32'hFFFF_FFFC;
            m_align = (new_pc[1:0] != 2'b00);
        end else begin
            m_align = 1'b0;
            do_pop  = (m_q.size() > 0) && ready;
            do_push = (m_q.size() < 4) || do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                e.pc  = m_pc;
                e.ins = fetched;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (we) m_im[w_addr[11:2]] = w_ins;
    endtask

    task automatic model_check();
        chk("m_pc", pc, m_pc);
        chk("m_count", 32'(count), 32'(m_q.size()));
        chk("m_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("m_align", 32'(align_err), 32'(m_align));
        if (m_q.size() > 0) begin
            chk("m_out_pc", out_pc, m_q[0].pc);
            chk("m_out_ins", out_ins, m_q[0].ins);
            chk("m_out_next_pc", out_next_pc, m_q[0].pc + 32'd4);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        model_check();
    endtask

    // Directed vectors: inputs applied for one edge, expected outputs after it
    typedef struct {
        logic        red;
        logic [31:0] npc;
        logic        rdy;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_val;
        logic [31:0] e_opc;
        logic [31:0] e_ins;
        logic        e_al;
    } vec_t;

    function automatic vec_t mk(logic red, logic [31:0] npc, logic rdy, logic [31:0] e_pc,
                                logic [2:0] e_cnt, logic e_val, logic [31:0] e_opc, logic e_al);
        vec_t v;
        v.red = red; v.npc = npc; v.rdy = rdy; v.e_pc = e_pc; v.e_cnt = e_cnt;
        v.e_val = e_val; v.e_opc = e_opc; v.e_ins = 32'hC0DE_0000 | (e_opc >> 2); v.e_al = e_al;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        // In-order streaming with ready high
        tbl[0]  = mk(0, 0, 1, 32'h04, 1, 1, 32'h00, 0);
        tbl[1]  = mk(0, 0, 1, 32'h08, 1, 1, 32'h04, 0);
        tbl[2]  = mk(0, 0, 1, 32'h0C, 1, 1, 32'h08, 0);
        tbl[3]  = mk(0, 0, 1, 32'h10, 1, 1, 32'h0C, 0);
        // Backpressure fill to full, then drain
        tbl[4]  = mk(1, 0, 0, 32'h00, 0, 0, 32'h00, 0);
        tbl[5]  = mk(0, 0, 0, 32'h04, 1, 1, 32'h00, 0);
        tbl[6]  = mk(0, 0, 0, 32'h08, 2, 1, 32'h00, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0C, 3, 1, 32'h00, 0);
        tbl[8]  = mk(0, 0, 0, 32'h10, 4, 1, 32'h00, 0);
        tbl[9]  = mk(0, 0, 0, 32'h10, 4, 1, 32'h00, 0);
        tbl[10] = mk(0, 0, 0, 32'h10, 4, 1, 32'h00, 0);
        tbl[11] = mk(0, 0, 0, 32'h10, 4, 1, 32'h00, 0);
        tbl[12] = mk(0, 0, 0, 32'h10, 4, 1, 32'h00, 0);
        tbl[13] = mk(0, 0, 1, 32'h14, 4, 1, 32'h04, 0);
        tbl[14] = mk(0, 0, 1, 32'h18, 4, 1, 32'h08, 0);
        tbl[15] = mk(0, 0, 1, 32'h1C, 4, 1, 32'h0C, 0);
        tbl[16] = mk(0, 0, 1, 32'h20, 4, 1, 32'h10, 0);
        tbl[17] = mk(0, 0, 1, 32'h24, 4, 1, 32'h14, 0);
        // Redirect while full with a concurrent pop
        tbl[18] = mk(1, 32'h40, 1, 32'h40, 0, 0, 32'h00, 0);
        tbl[19] = mk(0, 0, 1, 32'h44, 1, 1, 32'h40, 0);
        // Misaligned redirect: one-cycle flag
        tbl[20] = mk(1, 32'h42, 1, 32'h40, 0, 0, 32'h00, 1);
        tbl[21] = mk(0, 0, 1, 32'h44, 1, 1, 32'h40, 0);
        tbl[22] = mk(0, 0, 1, 32'h48, 1, 1, 32'h44, 0);
        // Back-to-back redirects: last one wins
        tbl[23] = mk(1, 32'h100, 1, 32'h100, 0, 0, 32'h00, 0);
        tbl[24] = mk(1, 32'h203, 1, 32'h200, 0, 0, 32'h00, 1);
        tbl[25] = mk(0, 0, 1, 32'h204, 1, 1, 32'h200, 0);

        rst = 1; redirect = 0; new_pc = 0; we = 0; w_addr = 0; w_ins = 0; ready = 0;
        rst6 = 1; redirect6 = 0; new_pc6 = 0; we6 = 0; w_addr6 = 0; w_ins6 = 0; ready6 = 0;
        m_pc = 0; m_align = 0;

        step();
        chk("reset_pc", pc, 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_align", 32'(align_err), 32'h0);

        // Load IM while redirect holds the fetch off
        rst = 0; redirect = 1; new_pc = 0; we = 1;
        for (int i = 0; i < 1024; i++) begin
            w_addr = 32'(i) << 2;
            w_ins  = 32'hC0DE_0000 | 32'(i);
            step();
        end
        we = 0; redirect = 0;

        for (int i = 0; i < 26; i++) begin
            redirect = tbl[i].red; new_pc = tbl[i].npc; ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_val", i), 32'(out_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_al", i), 32'(align_err), 32'(tbl[i].e_al));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_opc", i), out_pc, tbl[i].e_opc);
                chk($sformatf("tbl%0d_ins", i), out_ins, tbl[i].e_ins);
                chk($sformatf("tbl%0d_npc", i), out_next_pc, tbl[i].e_opc + 32'd4);
            end
        end

        // Write to the word being fetched: old word is queued, new word after refetch
        redirect = 1; new_pc = 32'h8; ready = 1;
        step();
        chk("wr_redir_pc", pc, 32'h8);
        redirect = 0; we = 1; w_addr = 32'h8; w_ins = 32'hDEAD_BEEF;
        step();
        we = 0;
        chk("wr_old_pc", out_pc, 32'h8);
        chk("wr_old_ins", out_ins, 32'hC0DE_0002);
        redirect = 1; new_pc = 32'h8;
        step();
        redirect = 0;
        step();
        chk("wr_new_pc", out_pc, 32'h8);
        chk("wr_new_ins", out_ins, 32'hDEAD_BEEF);
        chk("wr_new_next", out_next_pc, 32'hC);

        // Reset vector near the top of the address space, 4-word IM
        rst6 = 0; redirect6 = 1; new_pc6 = 32'hFFFF_FFF8; we6 = 1;
        for (int i = 0; i < 4; i++) begin
            w_addr6 = 32'(i) << 2;
            w_ins6  = 32'hB000_0000 | 32'(i);
            step();
        end
        we6 = 0; redirect6 = 0; ready6 = 0; rst6 = 1;
        step();
        chk("w6_rst_pc", pc6, 32'hFFFF_FFF8);
        chk("w6_rst_cnt", 32'(count6), 32'h0);
        rst6 = 0;
        step();
        chk("w6_pc1", pc6, 32'hFFFF_FFFC);
        chk("w6_head", out_pc6, 32'hFFFF_FFF8);
        chk("w6_head_ins", out_ins6, 32'hB000_0002);
        step();
        chk("w6_pc_wrap", pc6, 32'h0);
        step();
        chk("w6_pc3", pc6, 32'h4);
        chk("w6_cnt3", 32'(count6), 32'h3);
        chk("w6_next", out_next_pc6, 32'hFFFF_FFFC);
        rst6 = 1;
        step();
        chk("w6_mid_rst_cnt", 32'(count6), 32'h0);
        chk("w6_mid_rst_pc", pc6, 32'hFFFF_FFF8);
        chk("w6_mid_rst_val", 32'(out_valid6), 32'h0);
        rst6 = 0; ready6 = 1;
        step();
        chk("w6_d0_pc", out_pc6, 32'hFFFF_FFF8);
        chk("w6_d0_ins", out_ins6, 32'hB000_0002);
        step();
        chk("w6_d1_pc", out_pc6, 32'hFFFF_FFFC);
        chk("w6_d1_next", out_next_pc6, 32'h0);
        chk("w6_d1_ins", out_ins6, 32'hB000_0003);
        step();
        chk("w6_d2_pc", out_pc6, 32'h0);
        chk("w6_d2_ins", out_ins6, 32'hB000_0000);
        chk("w6_d2_fpc", pc6, 32'h4);

        // Random traffic against the reference model
        begin
            int bias;
            bias = 6;
            for (int c = 0; c < 4000; c++) begin
                if (c % 250 == 0) bias = $urandom_range(1, 10);
                rst      = ($urandom_range(0, 299) == 0);
                redirect = ($urandom_range(0, 19) == 0);
                new_pc   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
                ready    = ($urandom_range(0, 9) < bias);
                we       = !rst && ($urandom_range(0, 7) == 0);
                w_addr   = $urandom;
                w_ins    = $urandom;
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
